addsub_seq: RTL
===============

# addsub_seq

Parametrised, multi-cycle signed/unsigned adder/subtractor for the ALU datapath. It computes A±B with carry/borrow-in using a CHUNK-bit ripple slice that iterates LSB-first over N/CHUNK cycles, which keeps the carry chain short at wide N. It adds subtraction, saturation, a full flag set (carry, overflow, zero, negative) and valid/ready handshakes on both sides. It is the sequential successor of the combinational N-bit signed/unsigned full adder and sits between the operand registers and the ALU result mux.

## Interface
- N, default 16: operand/result width; must be a multiple of CHUNK, N ≥ 2.
- CHUNK, default 4: bits processed per cycle, 1 ≤ CHUNK ≤ N; K = N/CHUNK.
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  operands and mode valid.
- in_ready  out  1  block can accept operands; high only in IDLE.
- a, b  in  N  operands.
- cin  in  1  carry-in (add) or borrow-in (sub).
- sub  in  1  0 = A+B+cin; 1 = A−B−cin.
- sign  in  1  1 = two's-complement operands; 0 = unsigned.
- sat  in  1  1 = clamp result on overflow.
- out_valid  out  1  result and flags valid.
- out_ready  in  1  consumer accepts result.
- sum  out  N  result, after saturation.
- cout  out  1  raw carry-out for add; borrow (inverted carry-out) for sub.
- ovf  out  1  overflow: unsigned = cout; signed = carry[N] ^ carry[N−1].
- zero  out  1  sum == 0, taken after saturation.
- neg  out  1  sign & sum[N−1], taken after saturation.

## Operation
- FSM has three states: IDLE → RUN → DONE → IDLE.
- IDLE: in_ready = 1. On in_valid & in_ready, register a, b', mode bits and c0, clear the chunk index, and go to RUN.
  - b' = sub ? ~b : b.
  - c0 = sub ? ~cin : cin.
- RUN: each cycle add chunk i of a and b' with the running carry, then write the sum slice and the carry register. The carry into the top bit, carry[N−1], is retained for the overflow calculation.
- On the last chunk (i = K−1), compute the full result, flags and saturation combinationally from the final slice. Register all of them and go to DONE.
- Saturation applies only when sat = 1 and ovf = 1:
  - unsigned add → all ones;
  - unsigned sub → 0;
  - signed, with raw sum[N−1] = 1 (positive overflow) → 0111…1;
  - signed, with raw sum[N−1] = 0 (negative overflow) → 1000…0.
- cout and ovf always report the raw, unsaturated condition.
- DONE: out_valid = 1. sum and flags stay stable until out_valid & out_ready, then go to IDLE.
- Outputs keep the last result after the handshake, until the next result is written.
- Mode inputs are sampled only at the input handshake. Changes at any other time are ignored.
- The input side and output side do not overlap. A new operand is not accepted in the same cycle the result is taken.

## Timing
- Reset values: state = IDLE, in_ready = 1 (decoded from state), out_valid = 0, sum = 0, cout = ovf = zero = neg = 0, chunk index = 0.
- Latency: input handshake at edge 0; out_valid rises after edge K; result taken at the first edge ≥ K where out_ready = 1. With out_ready held high, the next in_ready is high one cycle after that.
- Throughput with out_ready held high is one operation per K+2 cycles.
- CHUNK = N gives K = 1: a single RUN cycle.
- Reset asserted in any state aborts the operation immediately, with no partial result. Outputs take their reset values asynchronously, and the first post-reset in_valid is accepted normally.
- in_valid in RUN or DONE is ignored; in_ready is 0 there.
- out_ready while out_valid = 0 has no effect.
- Carry wrap-around: the carry out of chunk K−1 is the final carry and is never fed back into chunk 0.

## Test plan
All scenarios use N = 8, CHUNK = 4 (K = 2) unless stated otherwise.
- Unsigned add, mode sub=0 sign=0 sat=0, a=200 b=100 cin=0 → sum=0x2C, cout=1, ovf=1, zero=0, neg=0; same operands with sat=1 → sum=0xFF, cout=1, ovf=1. out_valid rises exactly 2 edges after the input handshake.
- Signed add, mode sub=0 sign=1, a=100 b=50 → with sat=0: sum=0x96, ovf=1, neg=1, cout=0; with sat=1: sum=0x7F, neg=0. Then a=0x80 b=0xFF sat=1 → sum=0x80, ovf=1.
- Subtraction: unsigned 5−7 with cin=0 → sum=0xFE, cout=1 (borrow), ovf=1; with sat=1 → sum=0x00, zero=1. Signed 0x80−0x01 with sat=1 → sum=0x80, ovf=1, neg=1. Unsigned 9−3 with cin=1 → sum=0x05, cout=0.
- Zero and carry-chain: unsigned 0x80+0x80 → sum=0x00, zero=1, cout=1. 0xFF+0x00 with cin=1 → sum=0x00, cout=1 (checks carry crossing the chunk boundary). Repeat both with N=16, CHUNK=1 and with CHUNK=N.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → out_valid, sum and flags stable, in_ready=0, in_valid pulses ignored. Raise out_ready → one handshake, then in_ready=1 on the next cycle.
- Reset mid-operation: assert rst during RUN (after chunk 0) → all outputs zero, in_ready=1 immediately. Release rst and issue 3+4 → sum=7 after K edges, with no residue from the aborted operation.

Source files
------------

// File: rtl/addsub_seq.sv
// addsub_seq: multi-cycle signed/unsigned add/subtract that ripples CHUNK bits per cycle, LSB first,
// with saturation, carry/overflow/zero/negative flags and valid/ready handshakes on both sides.
module addsub_seq #(
   parameter int N     = 16,
   parameter int CHUNK = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         cin,
   input  logic         sub,
   input  logic         sign,
   input  logic         sat,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] sum,
   output logic         cout,
   output logic         ovf,
   output logic         zero,
   output logic         neg
);
   localparam int K  = N / CHUNK;
   localparam int IW = K > 1 ? $clog2(K) : 1;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t           r_state;
   logic [N-1:0]     r_a, r_b, r_acc, r_sum;
   logic [IW-1:0]    r_idx;
   logic             r_carry, r_sub, r_sign, r_sat;
   logic             r_out_valid, r_cout, r_ovf, r_zero, r_neg;
   logic [CHUNK-1:0] w_as, w_bs;
   logic [CHUNK:0]   w_ss;
   logic [N-1:0]     w_raw, w_sat_val, w_sum;
   logic             w_c, w_ctop, w_cout, w_ovf, w_last;

   assign w_as   = r_a[r_idx*CHUNK +: CHUNK];
   assign w_bs   = r_b[r_idx*CHUNK +: CHUNK];
   assign w_ss   = {1'b0, w_as} + {1'b0, w_bs} + (CHUNK+1)'(r_carry);
   assign w_c    = w_ss[CHUNK];
   // carry into bit N-1 recovered from the top bit of the last slice
   assign w_ctop = w_as[CHUNK-1] ^ w_bs[CHUNK-1] ^ w_ss[CHUNK-1];
   assign w_cout = r_sub ? ~w_c : w_c;
   assign w_ovf  = r_sign ? (w_c ^ w_ctop) : w_cout;
   assign w_last = r_idx == IW'(K-1);

   always_comb begin
      w_raw = r_acc;
      w_raw[N-1 -: CHUNK] = w_ss[CHUNK-1:0];
   end

   assign w_sat_val = r_sign ? (w_raw[N-1] ? {1'b0, {(N-1){1'b1}}} : {1'b1, {(N-1){1'b0}}})
                             : (r_sub ? '0 : '1);
   assign w_sum     = (r_sat && w_ovf) ? w_sat_val : w_raw;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_a         <= '0;
         r_b         <= '0;
         r_acc       <= '0;
         r_idx       <= '0;
         r_carry     <= 1'b0;
         r_sub       <= 1'b0;
         r_sign      <= 1'b0;
         r_sat       <= 1'b0;
         r_out_valid <= 1'b0;
         r_sum       <= '0;
         r_cout      <= 1'b0;
         r_ovf       <= 1'b0;
         r_zero      <= 1'b0;
         r_neg       <= 1'b0;
      end else if (r_state == IDLE) begin
         if (in_valid) begin
            r_a     <= a;
            r_b     <= sub ? ~b : b;
            r_carry <= sub ? ~cin : cin;
            r_sub   <= sub;
            r_sign  <= sign;
            r_sat   <= sat;
            r_idx   <= '0;
            r_state <= RUN;
         end
      end else if (r_state == RUN) begin
         r_acc[r_idx*CHUNK +: CHUNK] <= w_ss[CHUNK-1:0];
         r_carry <= w_c;
         r_idx   <= w_last ? '0 : r_idx + 1'b1;
         if (w_last) begin
            r_sum       <= w_sum;
            r_cout      <= w_cout;
            r_ovf       <= w_ovf;
            r_zero      <= w_sum == '0;
            r_neg       <= r_sign & w_sum[N-1];
            r_out_valid <= 1'b1;
            r_state     <= DONE;
         end
      end else if (r_state == DONE) begin
         if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
         end
      end else begin
         r_state <= IDLE;
      end
   end

   assign in_ready  = r_state == IDLE;
   assign out_valid = r_out_valid;
   assign sum       = r_sum;
   assign cout      = r_cout;
   assign ovf       = r_ovf;
   assign zero      = r_zero;
   assign neg       = r_neg;
endmodule
